difftest_retire_queue: RTL

DIFFTEST_RETIRE_QUEUE -- requirements
Module: difftest_retire_queue

---
 rtl/difftest_pkg.sv | 21 ++
 rtl/difftest_retire_queue_if.sv | 25 ++
 rtl/retire_fifo.sv | 51 +++++
 rtl/difftest_retire_queue.sv | 109 ++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// rtl/difftest_pkg.sv - shared widths, retire-entry layout and FSM states for the difftest retire queue
package difftest_pkg;

  localparam int XLEN = 64;
  localparam int NGPR = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            rd_wen;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            ebreak;
  } retire_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } retire_state_t;

endpackage

// File: rtl/difftest_retire_queue_if.sv
// rtl/difftest_retire_queue_if.sv - writeback-to-retire-queue offer/accept bundle
interface difftest_retire_queue_if #(
  parameter int XLEN = 64
);

  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_pc;
  logic [XLEN-1:0] wb_npc;
  logic            wb_rd_wen;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_rd_data;
  logic            wb_ebreak;

  modport master (
    output wb_valid, wb_pc, wb_npc, wb_rd_wen, wb_rd_addr, wb_rd_data, wb_ebreak,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_pc, wb_npc, wb_rd_wen, wb_rd_addr, wb_rd_data, wb_ebreak,
    output wb_ready
  );

endinterface

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - circular storage of retire entries with wrap-around pointers and occupancy count
module retire_fifo
  import difftest_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  retire_entry_t              push_data,
  input  logic                       pop,
  output retire_entry_t              head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  retire_entry_t   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/difftest_retire_queue.sv
// rtl/difftest_retire_queue.sv - buffers retiring instructions and replays them as commit pulses with a shadow GPR file
module difftest_retire_queue
  import difftest_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  difftest_retire_queue_if.slave   wb,
  input  logic                     sink_ready,
  output logic                     inst_commit,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          debug_pc,
  output logic [NGPR*XLEN-1:0]     gpr_wire,
  output logic                     cpu_ebreak_sign,
  output logic [63:0]              commit_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  retire_state_t   state;
  retire_state_t   state_next;
  retire_entry_t   push_entry;
  retire_entry_t   head_entry;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] gpr [1:NGPR-1];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Acceptance ignores sink_ready so writeback only stalls on a full queue or halt.
  assign wb.wb_ready = reset && (state == ST_RUN) && !full;
  assign push        = wb.wb_valid && wb.wb_ready;
  assign pop         = (state == ST_RUN) && !empty && sink_ready;

  always_comb begin
    push_entry         = '0;
    push_entry.pc      = wb.wb_pc;
    push_entry.npc     = wb.wb_npc;
    push_entry.rd_wen  = wb.wb_rd_wen;
    push_entry.rd_addr = wb.wb_rd_addr;
    push_entry.rd_data = wb.wb_rd_data;
    push_entry.ebreak  = wb.wb_ebreak;
  end

  retire_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (pop && head_entry.ebreak) begin
      state_next = ST_HALT;
    end
  end

  // The shadow GPR write lands on the pop edge so it is visible alongside inst_commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      inst_commit     <= 1'b0;
      cpu_ebreak_sign <= 1'b0;
      pc              <= '0;
      debug_pc        <= '0;
      commit_cnt      <= '0;
      for (int i = 1; i < NGPR; i++) begin
        gpr[i] <= '0;
      end
    end else begin
      inst_commit     <= pop;
      cpu_ebreak_sign <= pop && head_entry.ebreak;
      if (pop) begin
        pc         <= head_entry.npc;
        debug_pc   <= head_entry.pc;
        commit_cnt <= commit_cnt + 64'd1;
        if (head_entry.rd_wen && (head_entry.rd_addr != 5'd0)) begin
          gpr[head_entry.rd_addr] <= head_entry.rd_data;
        end
      end
    end
  end

  assign gpr_wire[XLEN-1:0] = '0;

  for (genvar g = 1; g < NGPR; g++) begin : g_gpr_wire
    assign gpr_wire[g*XLEN +: XLEN] = gpr[g];
  end

endmodule
